// File: rtl/logic_pattern_generator.sv
// Pattern generator that plays entries 0..length from a small pattern memory.
// Each entry is held for prescale+1 clocks; supports single-shot, loop and triggered starts.
module logic_pattern_generator #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] length,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  loop_en,
  input  logic                  trig_en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  trig,
  output logic [WIDTH-1:0]      pattern_out,
  output logic                  busy,
  output logic                  armed,
  output logic                  wrap,
  output logic                  done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t                  state, state_next;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   index, index_inc, sh_length;
  logic [PRESCALE_W-1:0]   div, sh_prescale;
  logic                    sh_loop;
  logic                    latch, enter_run, advance, restart, finish;
  logic                    entry_end, last_entry;

  // Memory has no reset; a same-edge read in RUN sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign index_inc  = index + DEPTH_LOG2'(1);
  assign entry_end  = (div == sh_prescale);
  assign last_entry = (index == sh_length);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Stop has priority over every other event, including natural completion.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    enter_run  = 1'b0;
    advance    = 1'b0;
    restart    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          latch      = 1'b1;
          enter_run  = !trig_en;
          state_next = trig_en ? ARMED : RUN;
        end
      end
      ARMED: begin
        if (stop) begin
          state_next = IDLE;
        end else if (trig) begin
          enter_run  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (entry_end) begin
          if (!last_entry) begin
            advance = 1'b1;
          end else if (sh_loop) begin
            restart = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_out <= '0;
      index       <= '0;
      div         <= '0;
      sh_length   <= '0;
      sh_prescale <= '0;
      sh_loop     <= 1'b0;
      wrap        <= 1'b0;
      done        <= 1'b0;
    end else begin
      wrap <= restart;
      done <= finish;
      if (latch) begin
        sh_length   <= length;
        sh_prescale <= prescale;
        sh_loop     <= loop_en;
      end
      if (enter_run || restart) begin
        pattern_out <= mem[0];
        index       <= '0;
        div         <= '0;
      end else if (advance) begin
        pattern_out <= mem[index_inc];
        index       <= index_inc;
        div         <= '0;
      end else if (state == RUN && !entry_end) begin
        div <= div + PRESCALE_W'(1);
      end
    end
  end

  assign busy  = (state != IDLE);
  assign armed = (state == ARMED);

endmodule

// File: tb/tb_logic_pattern_generator.sv
// Directed bench for logic_pattern_generator: vector table for the plain runs,
// hand-written sequences for trigger, stop, reset and live-write corner cases.
module tb_logic_pattern_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  length;
  logic [15:0] prescale;
  logic        loop_en, trig_en, start, stop, trig;
  logic [7:0]  pattern_out;
  logic        busy, armed, wrap, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        start, stop, trig, ten, lp;
    logic [3:0]  len;
    logic [15:0] pre;
    logic [7:0]  pat;
    logic        busy, armed, wrap, done;
  } vec_t;

  vec_t vecs [18];

  logic_pattern_generator #(.WIDTH(8), .DEPTH_LOG2(4), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length(length), .prescale(prescale), .loop_en(loop_en), .trig_en(trig_en),
    .start(start), .stop(stop), .trig(trig), .pattern_out(pattern_out),
    .busy(busy), .armed(armed), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, p, t, te, l, input logic [3:0] ln,
                              input logic [15:0] pr, input logic [7:0] pt,
                              input logic b, a, w, d);
    vec_t v;
    v = '{start: s, stop: p, trig: t, ten: te, lp: l, len: ln, pre: pr,
          pat: pt, busy: b, armed: a, wrap: w, done: d};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare {pattern_out, busy, armed, wrap, done} in one go.
  task automatic check_outs(input string name, input logic [7:0] pt,
                            input logic b, a, w, d);
    check(name, {20'd0, pattern_out, busy, armed, wrap, done}, {20'd0, pt, b, a, w, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] ln, input logic [15:0] pr, input logic l, input logic te);
    length = ln; prescale = pr; loop_en = l; trig_en = te;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg(4'd0, 16'd0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0; trig = 1'b0;

    // Single shot, len 3, prescale 1; config inputs scrambled after start.
    vecs[0]  = mk(1,0,0,0,0, 4'd3, 16'd1, 8'h11, 1,0,0,0);
    vecs[1]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h11, 1,0,0,0);
    vecs[2]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h22, 1,0,0,0);
    vecs[3]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h22, 1,0,0,0);
    vecs[4]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h33, 1,0,0,0);
    vecs[5]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h33, 1,0,0,0);
    vecs[6]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h44, 1,0,0,0);
    vecs[7]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h44, 1,0,0,0);
    vecs[8]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h44, 0,0,0,1);
    vecs[9]  = mk(0,0,0,0,0, 4'd0, 16'd0, 8'h44, 0,0,0,0);
    // Loop, len 3, prescale 0; loop_en dropped mid-run must not end it.
    vecs[10] = mk(1,0,0,0,1, 4'd3, 16'd0, 8'h11, 1,0,0,0);
    vecs[11] = mk(0,0,0,0,0, 4'd1, 16'd3, 8'h22, 1,0,0,0);
    vecs[12] = mk(0,0,0,0,0, 4'd1, 16'd3, 8'h33, 1,0,0,0);
    vecs[13] = mk(0,0,0,0,0, 4'd1, 16'd3, 8'h44, 1,0,0,0);
    vecs[14] = mk(0,0,0,0,0, 4'd1, 16'd3, 8'h11, 1,0,1,0);
    vecs[15] = mk(0,0,0,0,0, 4'd1, 16'd3, 8'h22, 1,0,0,0);
    vecs[16] = mk(0,1,0,0,0, 4'd1, 16'd3, 8'h22, 0,0,0,0);
    vecs[17] = mk(0,0,0,0,0, 4'd1, 16'd3, 8'h22, 0,0,0,0);

    #1;
    check_outs("reset_state", 8'h00, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    write_mem(4'd0, 8'h11);
    write_mem(4'd1, 8'h22);
    write_mem(4'd2, 8'h33);
    write_mem(4'd3, 8'h44);
    check_outs("idle_after_writes", 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; trig = vecs[i].trig;
      cfg(vecs[i].len, vecs[i].pre, vecs[i].lp, vecs[i].ten);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].pat, vecs[i].busy, vecs[i].armed,
                 vecs[i].wrap, vecs[i].done);
    end
    start = 1'b0; stop = 1'b0;

    // Triggered start; a trig on the start cycle is ignored, as is a start while armed.
    cfg(4'd3, 16'd0, 1'b0, 1'b1);
    start = 1'b1; trig = 1'b1;
    step();
    start = 1'b0; trig = 1'b0;
    check_outs("trig_armed", 8'h22, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      step();
      check_outs($sformatf("trig_wait%0d", i), 8'h22, 1, 1, 0, 0);
    end
    start = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    check_outs("trig_run0", 8'h11, 1, 0, 0, 0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check_outs("trig_run1", 8'h22, 1, 0, 0, 0);
    step(); check_outs("trig_run2", 8'h33, 1, 0, 0, 0);
    step(); check_outs("trig_run3", 8'h44, 1, 0, 0, 0);
    step(); check_outs("trig_done", 8'h44, 0, 0, 0, 1);

    // Start and stop together stay idle, armed mode or not.
    start = 1'b1; stop = 1'b1;
    step();
    check_outs("startstop_trig", 8'h44, 0, 0, 0, 0);
    cfg(4'd3, 16'd0, 1'b0, 1'b0);
    step();
    check_outs("startstop_run", 8'h44, 0, 0, 0, 0);
    start = 1'b0; stop = 1'b0;

    // Length 0, single shot.
    cfg(4'd0, 16'd0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    check_outs("len0_run", 8'h11, 1, 0, 0, 0);
    step(); check_outs("len0_done", 8'h11, 0, 0, 0, 1);

    // Length 0, loop: wrap every cycle after the first.
    cfg(4'd0, 16'd0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    check_outs("len0_loop0", 8'h11, 1, 0, 0, 0);
    step(); check_outs("len0_loop1", 8'h11, 1, 0, 1, 0);
    step(); check_outs("len0_loop2", 8'h11, 1, 0, 1, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check_outs("len0_stop", 8'h11, 0, 0, 0, 0);

    // Stop on the final cycle of a single-shot run suppresses done.
    cfg(4'd1, 16'd0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    check_outs("laststop_e0", 8'h11, 1, 0, 0, 0);
    step(); check_outs("laststop_e1", 8'h22, 1, 0, 0, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check_outs("laststop_idle", 8'h22, 0, 0, 0, 0);
    step(); check_outs("laststop_nodone", 8'h22, 0, 0, 0, 0);

    // Asynchronous reset mid-run, then a fresh run from entry 0.
    cfg(4'd3, 16'd0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    step(); check_outs("rst_prerun", 8'h22, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_outs("rst_async", 8'h00, 0, 0, 0, 0);
    step(); step();
    check_outs("rst_held", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;
    cfg(4'd3, 16'd0, 1'b0, 1'b0);
    step(); check_outs("rst_idle", 8'h00, 0, 0, 0, 0);
    start = 1'b1; step(); start = 1'b0;
    check_outs("rst_replay0", 8'h11, 1, 0, 0, 0);
    step(); check_outs("rst_replay1", 8'h22, 1, 0, 0, 0);
    step(); step();
    step(); check_outs("rst_replay_done", 8'h44, 0, 0, 0, 1);

    // Live write during a loop: same-edge read sees old data, next pass the new.
    cfg(4'd3, 16'd0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    check_outs("live_e0", 8'h11, 1, 0, 0, 0);
    step(); check_outs("live_e1", 8'h22, 1, 0, 0, 0);
    write_mem(4'd2, 8'hAA);
    check_outs("live_old", 8'h33, 1, 0, 0, 0);
    step(); check_outs("live_e3", 8'h44, 1, 0, 0, 0);
    step(); check_outs("live_wrap", 8'h11, 1, 0, 1, 0);
    step(); check_outs("live_e1b", 8'h22, 1, 0, 0, 0);
    step(); check_outs("live_new", 8'hAA, 1, 0, 0, 0);
    stop = 1'b1; step(); stop = 1'b0;
    check_outs("live_stop", 8'hAA, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_pattern_generator.md
LOGIC_PATTERN_GENERATOR -- requirements
Module: logic_pattern_generator

Interface
REQ-001 Parameter WIDTH, default 8: number of digital output channels.
REQ-002 Parameter DEPTH_LOG2, default 4: pattern memory depth is 2**DEPTH_LOG2 entries.
REQ-003 Parameter PRESCALE_W, default 16: width of the sample-period divider.
REQ-004 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-005 Ports, in order:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- wr_en, in, 1: pattern memory write strobe.
- wr_addr, in, DEPTH_LOG2: write address.
- wr_data, in, WIDTH: write data.
- length, in, DEPTH_LOG2: index of last pattern entry (entries 0..length are played).
- prescale, in, PRESCALE_W: each entry is held for prescale+1 clk cycles.
- loop_en, in, 1: repeat the pattern until stopped.
- trig_en, in, 1: the start command arms the block and waits for trig.
- start, in, 1: single-cycle start command.
- stop, in, 1: single-cycle abort command.
- trig, in, 1: trigger pulse (from trigger_hub state).
- pattern_out, out, WIDTH: registered digital output.
- busy, out, 1: high in ARMED or RUN.
- armed, out, 1: high in ARMED.
- wrap, out, 1: one-cycle pulse when the pattern restarts in loop mode.
- done, out, 1: one-cycle pulse on natural completion.

Function
REQ-006 The state machine SHALL have three states: IDLE, ARMED and RUN.
REQ-007 Pattern memory SHALL be written on any clk edge with wr_en=1, in any state; a RUN read of the same address on the same edge SHALL return the old data.
REQ-008 When start=1 and stop=0 in IDLE, the block SHALL latch length, prescale and loop_en into shadow registers; later changes to these inputs SHALL NOT affect the current run.
REQ-009 The IDLE transition on that start SHALL be to RUN if trig_en=0, or to ARMED if trig_en=1.
REQ-010 In ARMED, trig=1 SHALL move the block to RUN; trig while in IDLE or RUN SHALL be ignored, including a trig that coincides with the start cycle.
REQ-011 On the edge entering RUN, the block SHALL load pattern_out<=mem[0], set the index to 0 and clear the divider.
REQ-012 In RUN, each entry SHALL be held for exactly shadow prescale+1 cycles, after which pattern_out<=mem[index+1].
REQ-013 At the end of entry shadow length with loop=1: pattern_out<=mem[0], index<=0, wrap=1 for that one cycle.
REQ-014 At the end of entry shadow length with loop=0: the block SHALL return to IDLE, pulse done=1 for one cycle, and hold pattern_out at its last value.
REQ-015 When length=0, the block SHALL play entry 0 only, with the same loop and done rules.
REQ-016 When prescale=0, the output SHALL advance one entry per clk cycle.
REQ-017 The divider and index SHALL wrap cleanly at full scale (all-ones) with no overflow.
REQ-018 A stop in ARMED or RUN SHALL return the block to IDLE on the next edge, with no done and no wrap, and pattern_out held.
REQ-019 When stop and start are both 1 in the same cycle, stop SHALL win and the block SHALL stay in or enter IDLE.
REQ-020 A stop on the final cycle of a non-loop run SHALL suppress done.
REQ-021 A start while ARMED or RUN SHALL be ignored.
REQ-022 busy SHALL equal (state!=IDLE) and armed SHALL equal (state==ARMED), both decoded from registered state.

Reset
REQ-023 Asserting rst SHALL immediately force: state=IDLE, pattern_out=0, busy=0, armed=0, wrap=0, done=0, index=0, divider=0, and shadow registers=0.
REQ-024 Pattern memory contents SHALL be undefined after reset and SHALL NOT be cleared.
REQ-025 When rst is asserted mid-RUN, the block SHALL abort with no done pulse; the first start after rst release SHALL behave as from power-up.

Verification
REQ-026 Single shot: mem[0..3]=0x11,0x22,0x33,0x44; length=3, prescale=1, loop=0; start -> pattern_out shows 0x11,0x11,0x22,0x22,0x33,0x33,0x44,0x44, then done=1 for one cycle concurrent with the IDLE return, and pattern_out stays 0x44.
REQ-027 Loop: same data, prescale=0, loop=1 -> 0x11,0x22,0x33,0x44,0x11...; wrap=1 exactly on each return to 0x11 after the first; stop -> IDLE next edge, no done.
REQ-028 Triggered: trig_en=1; start -> armed=1 and pattern_out unchanged for 20 cycles; trig pulse -> RUN next edge with pattern_out=mem[0]; trig coinciding with start -> remains ARMED.
REQ-029 Boundaries: length=0, prescale=0, loop=0 -> one cycle of mem[0] then done; start+stop same cycle -> stays IDLE; length changed mid-run -> run length unchanged.
REQ-030 Reset mid-run: assert rst during RUN -> all outputs 0 asynchronously, no done; release rst, then start -> pattern replays from entry 0.
REQ-031 Live write: during loop run, write mem[2]=0xAA -> the next pass outputs 0xAA at entry 2.
